// File: rtl/seven_segs_capture.sv
// seven_segs_capture: receive side of a multiplexed seven-segment display bus.
// Samples the shared segment lines and one-hot digit strobes, waits for the
// bus to stay unchanged for STABLE_CYCLES samples, then decodes the glyph
// back to a hex digit for the strobed position.
// Optional build macro SEG_ACTIVE_LOW_EN: invert Segs and An in the sample
// stage, for common-anode boards with active-low segments and strobes.
module seven_segs_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [6:0]              Segs,
    input  logic [NUM_DIGITS-1:0]   An,
    input  logic                    Clear,
    output logic [4*NUM_DIGITS-1:0] Digits,
    output logic [NUM_DIGITS-1:0]   DigitValid,
    output logic                    Update,
    output logic [2:0]              UpdateIdx,
    output logic                    BadPattern,
    output logic                    AnodeErr
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HELD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [6:0]              segs_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              snapSegs_q, snapSegs_d;
    logic [NUM_DIGITS-1:0]   snapAn_q, snapAn_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d;
    logic [2:0]              idx_q, idx_d;
    logic                    bad_q, bad_d;
    logic                    anodeErr_q, anodeErr_d;

    logic                    sampleMatch;
    logic                    multiHot;
    logic [2:0]              snapIdx;
    logic                    glyphOk;
    logic [3:0]              glyphVal;

    // Sample stage: register the pins once so the FSM only sees clean values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            segs_q <= '0;
            an_q   <= '0;
        end else begin
`ifdef SEG_ACTIVE_LOW_EN
            segs_q <= ~Segs;
            an_q   <= ~An;
`else
            segs_q <= Segs;
            an_q   <= An;
`endif
        end
    end

    // Snapshot helpers: strobe index, multi-hot detection and glyph decode.
    always_comb begin
        sampleMatch = (an_q == snapAn_q) && (segs_q == snapSegs_q);
        multiHot    = (snapAn_q & (snapAn_q - NUM_DIGITS'(1))) != '0;
        snapIdx     = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (snapAn_q[i]) snapIdx = 3'(i);
        end
        glyphOk  = 1'b1;
        glyphVal = 4'h0;
        case (snapSegs_q)
            7'h3F: glyphVal = 4'h0;
            7'h06: glyphVal = 4'h1;
            7'h5B: glyphVal = 4'h2;
            7'h4F: glyphVal = 4'h3;
            7'h66: glyphVal = 4'h4;
            7'h6D: glyphVal = 4'h5;
            7'h7D: glyphVal = 4'h6;
            7'h07: glyphVal = 4'h7;
            7'h7F: glyphVal = 4'h8;
            7'h6F: glyphVal = 4'h9;
            7'h77: glyphVal = 4'hA;
            7'h7C: glyphVal = 4'hB;
            7'h39: glyphVal = 4'hC;
            7'h5E: glyphVal = 4'hD;
            7'h79: glyphVal = 4'hE;
            7'h71: glyphVal = 4'hF;
            default: glyphOk = 1'b0;
        endcase
    end

    // Next-state logic: stability filter FSM plus the capture actions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snapSegs_d = snapSegs_q;
        snapAn_d   = snapAn_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        update_d   = 1'b0;
        idx_d      = idx_q;
        bad_d      = Clear ? 1'b0 : bad_q;
        anodeErr_d = Clear ? 1'b0 : anodeErr_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (an_q != '0) begin
                    state_d    = SETTLE;
                    cnt_d      = CW'(1);
                    snapAn_d   = an_q;
                    snapSegs_d = segs_q;
                end
            end
            SETTLE: begin
                if (sampleMatch) begin
                    if (cnt_q >= CNT_MAX - CW'(1)) begin
                        state_d = CAPTURE;
                        cnt_d   = CNT_MAX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (an_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = CW'(1);
                    snapAn_d   = an_q;
                    snapSegs_d = segs_q;
                end
            end
            CAPTURE: begin
                state_d = HELD;
                if (multiHot) begin
                    anodeErr_d = 1'b1;
                end else begin
                    update_d = 1'b1;
                    idx_d    = snapIdx;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (snapAn_q[i]) begin
                            if (glyphOk) begin
                                digits_d[4*i +: 4] = glyphVal;
                                valid_d[i]         = 1'b1;
                            end else begin
                                valid_d[i] = 1'b0;
                            end
                        end
                    end
                    if (!glyphOk && (snapSegs_q != 7'h00)) bad_d = 1'b1;
                end
            end
            HELD: begin
                if (!sampleMatch) begin
                    if (an_q == '0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d    = SETTLE;
                        cnt_d      = CW'(1);
                        snapAn_d   = an_q;
                        snapSegs_d = segs_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register: FSM, snapshot and all registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            snapSegs_q <= '0;
            snapAn_q   <= '0;
            digits_q   <= '0;
            valid_q    <= '0;
            update_q   <= 1'b0;
            idx_q      <= 3'd0;
            bad_q      <= 1'b0;
            anodeErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snapSegs_q <= snapSegs_d;
            snapAn_q   <= snapAn_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            idx_q      <= idx_d;
            bad_q      <= bad_d;
            anodeErr_q <= anodeErr_d;
        end
    end

    assign Digits     = digits_q;
    assign DigitValid = valid_q;
    assign Update     = update_q;
    assign UpdateIdx  = idx_q;
    assign BadPattern = bad_q;
    assign AnodeErr   = anodeErr_q;

endmodule
